cursor_tracker: RTL and testbench
=================================

# cursor_tracker

Parametrised text-cursor tracker for the character-mode VGA terminal path. It consumes keyboard ASCII strobes and buffer-replay characters, and maintains the (row, column) cursor. It produces registered write commands (address, data, enable) for the character RAM, and keeps a bounded position history so backspace restores the exact prior location, including across line breaks.

## Interface
Parameters:
- ROWS, 30, number of text rows
- COLS, 70, number of text columns
- LMARGIN, 10, first usable column; must be less than COLS-1
- HIST_DEPTH, 32, backspace history entries; power of two

Ports:
- clk  in  1  system clock
- clear  in  1  synchronous, active-high reset
- ready  in  1  keyboard character valid (level); rising edge = one keystroke
- res_ascii  in  8  keyboard character
- put_back  in  1  replay mode (level); rising edge starts replay
- back_ascii  in  8  replay character, consumed every cycle while put_back=1
- loc_x  out  $clog2(ROWS)  cursor row
- loc_y  out  $clog2(COLS)  cursor column
- wren  out  1  one-cycle character RAM write strobe
- wr_x  out  $clog2(ROWS)  write row
- wr_y  out  $clog2(COLS)  write column
- wr_data  out  8  write character
- hist_empty  out  1  history holds no entries
- scroll  out  1  one-cycle pulse; present only with CURSOR_SCROLL_EN

## Operation
- Reset values: loc_x=0, loc_y=LMARGIN, wren=0, wr_x=0, wr_y=0, wr_data=0, hist_empty=1, scroll=0, history count=0.
- During clear, the edge-detect registers load the current ready/put_back values, so an input held high through reset produces no edge.
- Event priority per cycle: clear > ready rising edge > put_back rising edge > put_back level.
- Code 0 is ignored on both sources.
- Keyboard character handling:
  - 0x08 backspace: if history is non-empty, pop it, set the cursor to the popped entry, and write 0x20 there (wren=1). If history is empty, do nothing.
  - 0x0A newline: push the cursor, then set row+1, col=LMARGIN. No write.
  - 0x0D carriage return: set col=LMARGIN. No push, no write.
  - 0x20..0x7E printable: write the character at the current cursor and push the cursor. Then col+1; if col was COLS-1, go to row+1, col=LMARGIN instead.
  - Any other code is ignored.
- Replay:
  - put_back rising edge sets col=LMARGIN and keeps the row. back_ascii is not consumed that cycle.
  - In each following cycle with put_back=1, back_ascii is handled like the keyboard rules, with no history push or pop and with 0x08 ignored.
- Row advance from ROWS-1 (newline or wrap) is governed by Configuration.
- History is a circular stack. A push when full overwrites the oldest entry and the count stays at HIST_DEPTH.
- Arithmetic: row/column increments saturate per the rules above and never exceed ROWS-1 or COLS-1.

## Timing
- All outputs are registered.
- An event sampled at rising edge N (ready=1, with the previous sample 0) is visible on loc_*, wr_*, and wren after edge N.
- wren is high for exactly one cycle per write. wr_* holds its value until the next write.
- Throughput: one keyboard event per two cycles minimum, because an edge is needed. Replay runs at one character per cycle.
- A ready edge coinciding with replay is served first. The replay character in that cycle is dropped, and the source must hold it.
- A clear asserted mid-replay or mid-edge aborts the operation. Reset values apply on the next cycle.

## Configuration
- CURSOR_SCROLL_EN defined:
  - Row advance at ROWS-1 keeps row=ROWS-1, sets col=LMARGIN, and pulses scroll for 1 cycle.
  - History is cleared on that same cycle, because the stored positions become stale.
- Undefined:
  - Row advance wraps to row 0 and the history is retained.
  - The scroll port is absent.

## Structure
- Package cursor_pkg: ASCII constants (BS=8, LF=10, CR=13, SP=32, PRINT_LO=32, PRINT_HI=126), plus a packed typedef for a history entry (row, column).
- Sub-module cursor_hist_stack: parametrised circular stack with push, pop, clear, empty, full, and count. Its pop data is combinational from the top pointer.

## Test plan
- Reset, then ready edge with 'A' -> wren=1, wr=(0,10), wr_data=0x41, cursor=(0,11), hist_empty=0.
- 60 printable characters from (0,10) -> last write at (0,69), cursor=(1,10). Then backspace -> cursor=(0,69) and 0x20 written there.
- 'a', LF, BS, BS -> cursor returns to (0,11) then (0,10). A third BS causes no move and no wren.
- 40 pushes with HIST_DEPTH=32, then 40 BS -> exactly 32 moves, after which hist_empty=1 and further BS are ignored.
- put_back rise at cursor (3,25), then back_ascii "hi",LF,'x' on consecutive cycles -> writes at (3,10), (3,11), then (4,10); no history change.
- Cursor at (29,40), LF -> with CURSOR_SCROLL_EN: cursor=(29,10), scroll pulse, hist_empty=1. Without it: cursor=(0,10).

Source files
------------

// File: rtl/cursor_pkg.sv
// rtl/cursor_pkg.sv - ASCII codes and history entry type shared by the cursor tracker
// Contents: control/printable ASCII constants, hist_entry_t (row, col) for the backspace history.
package cursor_pkg;

    localparam logic [7:0] BS       = 8'h08;
    localparam logic [7:0] LF       = 8'h0A;
    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] SP       = 8'h20;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    // Fields are 8 bits so any grid up to 256x256 fits; the tracker zero-extends into them.
    typedef struct packed {
        logic [7:0] row;
        logic [7:0] col;
    } hist_entry_t;

endpackage

// File: rtl/cursor_tracker_if.sv
// rtl/cursor_tracker_if.sv - keyboard, replay and character-RAM write bundle of the cursor tracker
// Signals: ready/res_ascii (keyboard), put_back/back_ascii (replay), loc_x/loc_y (cursor),
// wren/wr_x/wr_y/wr_data (RAM write), hist_empty, scroll (only with CURSOR_SCROLL_EN).
// Modports: master = tracker side, slave = environment side.
interface cursor_tracker_if #(
    parameter int ROWS = 30,
    parameter int COLS = 70
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic          ready;
    logic [7:0]    res_ascii;
    logic          put_back;
    logic [7:0]    back_ascii;
    logic [RW-1:0] loc_x;
    logic [CW-1:0] loc_y;
    logic          wren;
    logic [RW-1:0] wr_x;
    logic [CW-1:0] wr_y;
    logic [7:0]    wr_data;
    logic          hist_empty;
`ifdef CURSOR_SCROLL_EN
    logic          scroll;

    modport master (
        input  ready, res_ascii, put_back, back_ascii,
        output loc_x, loc_y, wren, wr_x, wr_y, wr_data, hist_empty, scroll
    );
    modport slave (
        output ready, res_ascii, put_back, back_ascii,
        input  loc_x, loc_y, wren, wr_x, wr_y, wr_data, hist_empty, scroll
    );
`else
    modport master (
        input  ready, res_ascii, put_back, back_ascii,
        output loc_x, loc_y, wren, wr_x, wr_y, wr_data, hist_empty
    );
    modport slave (
        output ready, res_ascii, put_back, back_ascii,
        input  loc_x, loc_y, wren, wr_x, wr_y, wr_data, hist_empty
    );
`endif
endinterface

// File: rtl/cursor_hist_stack.sv
// rtl/cursor_hist_stack.sv - circular LIFO of cursor positions used for backspace
// Ports: clk, clear (sync, active-high), push/push_data, pop/pop_data (combinational from top),
// empty, full, count. A push when full overwrites the oldest entry; count saturates at DEPTH.
module cursor_hist_stack
    import cursor_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   push,
    input  hist_entry_t            push_data,
    input  logic                   pop,
    output hist_entry_t            pop_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;

    hist_entry_t   mem [DEPTH];
    logic [AW-1:0] top;     // next free slot; wraps, so at full it points at the oldest entry

    assign pop_data = mem[top - AW'(1)];
    assign empty    = (count == '0);
    assign full     = (count == NW'(DEPTH));

    always_ff @(posedge clk) begin
        if (clear) begin
            top   <= '0;
            count <= '0;
        end else if (push) begin
            top <= top + AW'(1);
            if (!full) begin
                count <= count + NW'(1);
            end
        end else if (pop && !empty) begin
            top   <= top - AW'(1);
            count <= count - NW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[top] <= push_data;
        end
    end

endmodule

// File: rtl/cursor_tracker.sv
// rtl/cursor_tracker.sv - text cursor tracker producing character-RAM writes with backspace history
// Ports: clk, clear (sync, active-high), bus (cursor_tracker_if.master).
// Option: CURSOR_SCROLL_EN - row advance past the last row holds the row, pulses scroll and clears history.
module cursor_tracker
    import cursor_pkg::*;
#(
    parameter int ROWS       = 30,
    parameter int COLS       = 70,
    parameter int LMARGIN    = 10,
    parameter int HIST_DEPTH = 32
) (
    input logic             clk,
    input logic             clear,
    cursor_tracker_if.master bus
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(LMARGIN);

    logic          ready_q, put_back_q;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          wren_q, wren_d;
    logic [RW-1:0] wr_x_q, wr_x_d;
    logic [CW-1:0] wr_y_q, wr_y_d;
    logic [7:0]    wr_data_q, wr_data_d;

    logic          ready_rise, pb_rise;
    logic          take, from_kb, adv;
    logic [7:0]    ch;
    logic          push, pop, hist_clr;
    hist_entry_t   push_data, pop_data;
    logic          hist_empty, hist_full;
    logic [$clog2(HIST_DEPTH):0] hist_count;
    logic          unused_bits;

`ifdef CURSOR_SCROLL_EN
    logic          scroll_d, scroll_q;
`endif

    assign ready_rise = bus.ready & ~ready_q;
    assign pb_rise    = bus.put_back & ~put_back_q;
    assign push_data  = '{row: 8'(row_q), col: 8'(col_q)};

    always_comb begin
        row_d     = row_q;
        col_d     = col_q;
        wren_d    = 1'b0;
        wr_x_d    = wr_x_q;
        wr_y_d    = wr_y_q;
        wr_data_d = wr_data_q;
        push      = 1'b0;
        pop       = 1'b0;
        adv       = 1'b0;
        take      = 1'b0;
        from_kb   = 1'b0;
        ch        = bus.res_ascii;
`ifdef CURSOR_SCROLL_EN
        scroll_d  = 1'b0;
`endif
        // A keystroke edge pre-empts replay; the replay character of that cycle is dropped.
        if (ready_rise) begin
            take    = 1'b1;
            from_kb = 1'b1;
        end else if (pb_rise) begin
            col_d = COL_FIRST;
        end else if (bus.put_back) begin
            take = 1'b1;
            ch   = bus.back_ascii;
        end

        if (take) begin
            if (ch == BS) begin
                if (from_kb && !hist_empty) begin
                    pop       = 1'b1;
                    row_d     = pop_data.row[RW-1:0];
                    col_d     = pop_data.col[CW-1:0];
                    wren_d    = 1'b1;
                    wr_x_d    = pop_data.row[RW-1:0];
                    wr_y_d    = pop_data.col[CW-1:0];
                    wr_data_d = SP;
                end
            end else if (ch == LF) begin
                push = from_kb;
                adv  = 1'b1;
            end else if (ch == CR) begin
                col_d = COL_FIRST;
            end else if (ch >= PRINT_LO && ch <= PRINT_HI) begin
                wren_d    = 1'b1;
                wr_x_d    = row_q;
                wr_y_d    = col_q;
                wr_data_d = ch;
                push      = from_kb;
                if (col_q == COL_LAST) begin
                    adv = 1'b1;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
        end

        if (adv) begin
            col_d = COL_FIRST;
            if (row_q == ROW_LAST) begin
`ifdef CURSOR_SCROLL_EN
                row_d    = row_q;
                scroll_d = 1'b1;
`else
                row_d    = '0;
`endif
            end else begin
                row_d = row_q + RW'(1);
            end
        end
    end

`ifdef CURSOR_SCROLL_EN
    // Stored positions refer to pre-scroll rows, so they are discarded on scroll.
    assign hist_clr = clear | scroll_d;
`else
    assign hist_clr = clear;
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            // Loading the live levels means an input held high through reset makes no edge.
            ready_q    <= bus.ready;
            put_back_q <= bus.put_back;
            row_q      <= '0;
            col_q      <= COL_FIRST;
            wren_q     <= 1'b0;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
            wr_data_q  <= '0;
        end else begin
            ready_q    <= bus.ready;
            put_back_q <= bus.put_back;
            row_q      <= row_d;
            col_q      <= col_d;
            wren_q     <= wren_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            wr_data_q  <= wr_data_d;
        end
    end

`ifdef CURSOR_SCROLL_EN
    always_ff @(posedge clk) begin
        if (clear) begin
            scroll_q <= 1'b0;
        end else begin
            scroll_q <= scroll_d;
        end
    end
    assign bus.scroll = scroll_q;
`endif

    cursor_hist_stack #(.DEPTH(HIST_DEPTH)) u_hist (
        .clk       (clk),
        .clear     (hist_clr),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .empty     (hist_empty),
        .full      (hist_full),
        .count     (hist_count)
    );

    assign unused_bits = ^{pop_data, hist_full, hist_count};

    assign bus.loc_x      = row_q;
    assign bus.loc_y      = col_q;
    assign bus.wren       = wren_q;
    assign bus.wr_x       = wr_x_q;
    assign bus.wr_y       = wr_y_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.hist_empty = hist_empty;

endmodule

// File: tb/tb_cursor_tracker.sv
// tb/tb_cursor_tracker.sv - directed self-checking bench for cursor_tracker
module tb_cursor_tracker;
    logic clk = 1'b0;
    logic clear;
    int   checks = 0;
    int   errors = 0;
    int   moves;

    logic       cap_wren;
    logic [4:0] cap_wx;
    logic [6:0] cap_wy;
    logic [7:0] cap_wd;
`ifdef CURSOR_SCROLL_EN
    logic       cap_scroll;
`endif

    cursor_tracker_if #(.ROWS(30), .COLS(70)) bus ();

    cursor_tracker #(.ROWS(30), .COLS(70), .LMARGIN(10), .HIST_DEPTH(32)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        bus.ready      = 1'b0;
        bus.res_ascii  = 8'h00;
        bus.put_back   = 1'b0;
        bus.back_ascii = 8'h00;
        clear          = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b0;
    endtask

    // One keystroke: edge in, capture the write strobe cycle, then release.
    task automatic key(input logic [7:0] c);
        bus.res_ascii = c;
        bus.ready     = 1'b1;
        @(negedge clk);
        cap_wren = bus.wren;
        cap_wx   = bus.wr_x;
        cap_wy   = bus.wr_y;
        cap_wd   = bus.wr_data;
`ifdef CURSOR_SCROLL_EN
        cap_scroll = bus.scroll;
`endif
        bus.ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_loc(input string tag, input int x, input int y);
        check({tag, "_x"}, 32'(bus.loc_x), 32'(x));
        check({tag, "_y"}, 32'(bus.loc_y), 32'(y));
    endtask

    task automatic check_wr(input string tag, input int x, input int y, input int d);
        check({tag, "_wren"}, 32'(cap_wren), 32'd1);
        check({tag, "_wx"}, 32'(cap_wx), 32'(x));
        check({tag, "_wy"}, 32'(cap_wy), 32'(y));
        check({tag, "_wd"}, 32'(cap_wd), 32'(d));
    endtask

    initial begin
        // Reset with ready held high: reset values, then no edge after release.
        bus.ready      = 1'b1;
        bus.res_ascii  = 8'h5A;
        bus.put_back   = 1'b0;
        bus.back_ascii = 8'h00;
        clear          = 1'b1;
        repeat (2) @(negedge clk);
        check_loc("rst", 0, 10);
        check("rst_wren", 32'(bus.wren), 32'd0);
        check("rst_wx", 32'(bus.wr_x), 32'd0);
        check("rst_wy", 32'(bus.wr_y), 32'd0);
        check("rst_wd", 32'(bus.wr_data), 32'd0);
        check("rst_empty", 32'(bus.hist_empty), 32'd1);
`ifdef CURSOR_SCROLL_EN
        check("rst_scroll", 32'(bus.scroll), 32'd0);
`endif
        clear = 1'b0;
        @(negedge clk);
        check("held_wren", 32'(bus.wren), 32'd0);
        check_loc("held", 0, 10);
        bus.ready = 1'b0;
        @(negedge clk);

        // First keystroke
        key(8'h41);
        check_wr("A", 0, 10, 8'h41);
        check_loc("A", 0, 11);
        check("A_empty", 32'(bus.hist_empty), 32'd0);
        check("A_wren_drop", 32'(bus.wren), 32'd0);

        // 60 printables wrap to next line, backspace returns across the break
        do_reset();
        for (int i = 0; i < 60; i++) key(8'(8'h41 + (i % 26)));
        check_wr("p60", 0, 69, 8'h48);
        check_loc("p60", 1, 10);
        key(8'h08);
        check_wr("p60bs", 0, 69, 8'h20);
        check_loc("p60bs", 0, 69);

        // a, LF, BS, BS, BS; code 0 ignored; CR not pushed
        do_reset();
        key(8'h61);
        check_loc("a", 0, 11);
        key(8'h0A);
        check("lf_wren", 32'(cap_wren), 32'd0);
        check_loc("lf", 1, 10);
        key(8'h08);
        check_wr("bs1", 0, 11, 8'h20);
        check_loc("bs1", 0, 11);
        key(8'h08);
        check_wr("bs2", 0, 10, 8'h20);
        check_loc("bs2", 0, 10);
        key(8'h08);
        check("bs3_wren", 32'(cap_wren), 32'd0);
        check_loc("bs3", 0, 10);
        check("bs3_empty", 32'(bus.hist_empty), 32'd1);
        key(8'h00);
        check("nul_wren", 32'(cap_wren), 32'd0);
        check_loc("nul", 0, 10);
        key(8'h62);
        key(8'h63);
        key(8'h0D);
        check("cr_wren", 32'(cap_wren), 32'd0);
        check_loc("cr", 0, 10);
        key(8'h08);
        check_wr("cr_bs", 0, 11, 8'h20);

        // History depth: 40 pushes, 40 backspaces, only 32 restore
        do_reset();
        for (int i = 0; i < 40; i++) key(8'h78);
        check_loc("h40", 0, 50);
        moves = 0;
        for (int i = 0; i < 40; i++) begin
            key(8'h08);
            if (cap_wren) moves++;
        end
        check("hist_moves", 32'(moves), 32'd32);
        check("hist_empty", 32'(bus.hist_empty), 32'd1);
        check_loc("hist_end", 0, 18);

        // Replay from (3,25), with a keystroke pre-empting one replay cycle
        do_reset();
        repeat (3) key(8'h0A);
        repeat (15) key(8'h70);
        check_loc("pre_rp", 3, 25);
        bus.back_ascii = 8'h00;
        bus.put_back   = 1'b1;
        @(negedge clk);
        check("rp_rise_wren", 32'(bus.wren), 32'd0);
        check_loc("rp_rise", 3, 10);
        bus.back_ascii = 8'h68;
        @(negedge clk);
        cap_wren = bus.wren; cap_wx = bus.wr_x; cap_wy = bus.wr_y; cap_wd = bus.wr_data;
        check_wr("rp_h", 3, 10, 8'h68);
        check_loc("rp_h", 3, 11);
        bus.back_ascii = 8'h69;
        @(negedge clk);
        cap_wren = bus.wren; cap_wx = bus.wr_x; cap_wy = bus.wr_y; cap_wd = bus.wr_data;
        check_wr("rp_i", 3, 11, 8'h69);
        bus.back_ascii = 8'h0A;
        @(negedge clk);
        check("rp_lf_wren", 32'(bus.wren), 32'd0);
        check_loc("rp_lf", 4, 10);
        bus.back_ascii = 8'h78;
        @(negedge clk);
        cap_wren = bus.wren; cap_wx = bus.wr_x; cap_wy = bus.wr_y; cap_wd = bus.wr_data;
        check_wr("rp_x", 4, 10, 8'h78);
        check_loc("rp_x", 4, 11);
        bus.back_ascii = 8'h71;
        bus.res_ascii  = 8'h6B;
        bus.ready      = 1'b1;
        @(negedge clk);
        cap_wren = bus.wren; cap_wx = bus.wr_x; cap_wy = bus.wr_y; cap_wd = bus.wr_data;
        check_wr("rp_kb", 4, 11, 8'h6B);
        check_loc("rp_kb", 4, 12);
        bus.ready = 1'b0;
        @(negedge clk);
        cap_wren = bus.wren; cap_wx = bus.wr_x; cap_wy = bus.wr_y; cap_wd = bus.wr_data;
        check_wr("rp_q", 4, 12, 8'h71);
        bus.put_back   = 1'b0;
        bus.back_ascii = 8'h00;
        @(negedge clk);
        key(8'h08);
        check_wr("rp_bs1", 4, 11, 8'h20);
        key(8'h08);
        check_wr("rp_bs2", 3, 24, 8'h20);
        check_loc("rp_bs2", 3, 24);

        // Row advance from the last row
        do_reset();
        repeat (29) key(8'h0A);
        repeat (30) key(8'h7A);
        check_loc("pre_last", 29, 40);
        key(8'h0A);
`ifdef CURSOR_SCROLL_EN
        check_loc("scroll", 29, 10);
        check("scroll_pulse", 32'(cap_scroll), 32'd1);
        check("scroll_after", 32'(bus.scroll), 32'd0);
        check("scroll_empty", 32'(bus.hist_empty), 32'd1);
`else
        check_loc("wrap", 0, 10);
        check("wrap_empty", 32'(bus.hist_empty), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
